hilo_seq_ctrl: RTL and testbench
================================

Name: hilo_seq_ctrl

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide unit; owns the HI and LO result registers.
- Accepts one operation at a time over a valid/ready handshake and runs an iterative shift-add multiply or restoring divide over N cycles.
- Serves move-from/move-to HI/LO requests.
- Sits between the instruction decode/issue logic and the register-file writeback path.

Parameters:
N, 4, operand width and width of each of HI and LO.

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
op  input  3  000 MULTU, 001 DIVU, 010 MFHI, 011 MFLO, 100 MTHI, 101 MTLO, 110/111 see Optional Feature
a  input  N  operand A / multiplicand / dividend / move-to data
b  input  N  operand B / multiplier / divisor
resp_valid  output  1  one-cycle pulse: resp_data valid
resp_data  output  N  HI or LO value for MFHI/MFLO
hi  output  N  HI register
lo  output  N  LO register
busy  output  1  multiply or divide in progress
done  output  1  one-cycle pulse: HI/LO updated by multiply or divide
div_by_zero  output  1  status flag from the last divide

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE; hi=lo=0; busy=done=resp_valid=div_by_zero=0; resp_data=0; req_ready=1.
  - Any in-flight operation is discarded.
- Accept condition: req_valid && req_ready at a rising edge.
  - req_ready = (state==IDLE), so requests are held off while busy.
  - Requesters keep req_valid, op, a and b stable until accepted.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- IDLE, on accept:
  - MULTU, DIVU: latch a and b; iteration count=0; clear div_by_zero. MULTU goes to MUL_RUN, DIVU goes to DIV_RUN.
  - MTHI: hi<=a at the accept edge. MTLO: lo<=a at the accept edge. Remain IDLE.
  - MFHI/MFLO: next cycle resp_valid=1 and resp_data=hi/lo as held at the accept edge. Remain IDLE.
  - Undefined op: accepted, no effect.
- MUL_RUN:
  - Unsigned shift-add, one multiplier bit per cycle.
  - Full 2N-bit product held in internal accumulators.
  - busy=1 for exactly N cycles.
  - On the Nth iteration edge: {hi,lo}<=a*b (hi = upper N bits); state->IDLE.
  - done=1 for the following cycle.
- DIV_RUN:
  - Unsigned restoring division, one quotient bit per cycle, N cycles.
  - On the final edge: lo<=a/b (quotient), hi<=a%b (remainder); state->IDLE; done=1 for the following cycle.
- Divide by zero (b==0):
  - Still takes N cycles.
  - Result is lo={N{1'b1}}, hi=a.
  - div_by_zero=1 from the done cycle until the next accepted MULTU/DIVU or reset.
- Register hold rules:
  - hi/lo are unchanged during MUL_RUN/DIV_RUN; intermediate values are never visible.
  - hi/lo update only on a completion edge, an MT* accept edge, or reset.
- Back-to-back timing:
  - A new request may be accepted in the cycle done=1, since req_ready is already 1.
  - An MFHI/MFLO accepted in that cycle returns the new result.
- Output stability:
  - resp_valid is 0 in every cycle other than the one following an MF* acceptance.
  - resp_data holds its last value when resp_valid is 0.
- Operation latency: accept edge + N cycles for multiply and divide; 1 cycle for MF*.

Optional Feature:
Macro HILO_SIGNED_EN.
- Defined: op 110=MULT (signed) and op 111=DIV (signed), two's complement.
  - Implemented by magnitude conversion, the same N-cycle iterative core, then sign fixup on the final edge. Latency is unchanged.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero gives the same result and flag as unsigned (hi=a, lo=all ones).
- Not defined: 110/111 are accepted as no-ops; no signed logic is synthesized.

Test Plan:
- N=4, MULTU a=13 b=11 -> busy=1 and req_ready=0 for 4 cycles, then done pulse with hi=0x8, lo=0xF.
- DIVU a=13 b=4 -> after 4 cycles lo=0x3, hi=0x1, div_by_zero=0. Then DIVU a=9 b=0 -> hi=0x9, lo=0xF, div_by_zero=1. Then MULTU 2*3 -> div_by_zero clears on accept.
- MTHI a=5, then MFLO, then MFHI on consecutive cycles -> resp_valid pulses returning 0x0 then 0x5; hi=5 visible the cycle after the MTHI accept.
- MULTU 15*15 with req_valid held and a second MFLO queued behind it -> MFLO not accepted until done cycle; its response returns lo=0x1 (hi=0xE).
- DIVU 14/3 with rst_n pulled low at iteration 2 -> immediate hi=lo=0, busy=0, req_ready=1; no done pulse follows.
- With HILO_SIGNED_EN: MULT -3*5 -> hi=0xF, lo=0x1. DIV -7/2 -> lo=0xD (-3), hi=0xF (-1). Without the macro: op 110 leaves hi/lo unchanged.

Source files
------------

// File: rtl/hilo_seq_ctrl.sv
// HI/LO multiply/divide sequencer: iterative shift-add MULTU, restoring DIVU, MF*/MT* moves.
// Define HILO_SIGNED_EN to add signed MULT (op 110) and DIV (op 111); otherwise those ops are no-ops.
module hilo_seq_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [2:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         resp_valid_o,
    output logic [N-1:0] resp_data_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         div_by_zero_o
);
    // state   | meaning
    // IDLE    | accepting requests, MF*/MT* served here
    // MUL_RUN | shift-add multiply, one multiplier bit per cycle
    // DIV_RUN | restoring divide, one quotient bit per cycle
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

    localparam int CW = $clog2(N + 1);

    state_t         state_q, state_d;
    logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic [N-1:0]   resp_data_q, resp_data_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d, resp_valid_q, resp_valid_d, dbz_q, dbz_d;

    logic [N:0]     sum, rem_sh;
    logic           qbit;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem;

`ifdef HILO_SIGNED_EN
    logic sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;

    function automatic logic [N-1:0] mag(input logic [N-1:0] v);
        return v[N-1] ? ({N{1'b0}} - v) : v;
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        opnd_d       = opnd_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        dbz_d        = dbz_q;
`ifdef HILO_SIGNED_EN
        sgn_d        = sgn_q;
        neg_a_d      = neg_a_q;
        neg_b_d      = neg_b_q;
`endif
        // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}
        sum    = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
        rem_sh = {acc_q[2*N-1:N], acc_q[N-1]};
        qbit   = 1'b0;
        if (rem_sh >= {1'b0, opnd_q}) begin
            rem_sh = rem_sh - {1'b0, opnd_q};
            qbit   = 1'b1;
        end
        prod = {sum, acc_q[N-1:1]};
        quo  = {acc_q[N-2:0], qbit};
        rem  = rem_sh[N-1:0];

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    case (op_i)
                        3'b000: begin
                            opnd_d  = a_i;
                            acc_d   = {{N{1'b0}}, b_i};
                            cnt_d   = CW'(N - 1);
                            dbz_d   = 1'b0;
                            state_d = MUL_RUN;
`ifdef HILO_SIGNED_EN
                            sgn_d   = 1'b0;
`endif
                        end
                        3'b001: begin
                            opnd_d  = b_i;
                            acc_d   = {{N{1'b0}}, a_i};
                            cnt_d   = CW'(N - 1);
                            dbz_d   = 1'b0;
                            state_d = DIV_RUN;
`ifdef HILO_SIGNED_EN
                            sgn_d   = 1'b0;
`endif
                        end
                        3'b010: begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = hi_q;
                        end
                        3'b011: begin
                            resp_valid_d = 1'b1;
                            resp_data_d  = lo_q;
                        end
                        3'b100: hi_d = a_i;
                        3'b101: lo_d = a_i;
`ifdef HILO_SIGNED_EN
                        3'b110: begin
                            opnd_d  = mag(a_i);
                            acc_d   = {{N{1'b0}}, mag(b_i)};
                            cnt_d   = CW'(N - 1);
                            dbz_d   = 1'b0;
                            sgn_d   = 1'b1;
                            neg_a_d = a_i[N-1];
                            neg_b_d = b_i[N-1];
                            state_d = MUL_RUN;
                        end
                        3'b111: begin
                            opnd_d  = mag(b_i);
                            acc_d   = {{N{1'b0}}, mag(a_i)};
                            cnt_d   = CW'(N - 1);
                            dbz_d   = 1'b0;
                            sgn_d   = 1'b1;
                            neg_a_d = a_i[N-1];
                            neg_b_d = b_i[N-1];
                            state_d = DIV_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            MUL_RUN: begin
                acc_d = prod;
                if (cnt_q == '0) begin
`ifdef HILO_SIGNED_EN
                    if (sgn_q && (neg_a_q ^ neg_b_q))
                        prod = {(2*N){1'b0}} - prod;
`endif
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DIV_RUN: begin
                acc_d = {rem, quo};
                if (cnt_q == '0) begin
                    // A zero divisor naturally yields quo = all ones and rem = |a|
`ifdef HILO_SIGNED_EN
                    if (sgn_q) begin
                        if ((neg_a_q ^ neg_b_q) && (opnd_q != '0))
                            quo = {N{1'b0}} - quo;
                        if (neg_a_q)
                            rem = {N{1'b0}} - rem;
                    end
`endif
                    lo_d    = quo;
                    hi_d    = rem;
                    dbz_d   = (opnd_q == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            opnd_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            dbz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            opnd_q       <= opnd_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            dbz_q        <= dbz_d;
        end
    end

`ifdef HILO_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            sgn_q   <= sgn_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end
`endif

    assign req_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_data_o   = resp_data_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// Directed self-checking bench for hilo_seq_ctrl (N=4); signed cases run when HILO_SIGNED_EN is defined.
module tb_hilo_seq_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   op = 3'b000;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         resp_valid;
    logic [N-1:0] resp_data;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;
    logic         dbz;

    int n_checks = 0;
    int n_pass   = 0;
    int seen_done;

    localparam logic [2:0] MULTU = 3'b000, DIVU = 3'b001, MFHI = 3'b010,
                           MFLO = 3'b011, MTHI = 3'b100, MTLO = 3'b101;

    always #5 clk = ~clk;

    hilo_seq_ctrl #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .resp_valid_o  (resp_valid),
        .resp_data_o   (resp_data),
        .hi_o          (hi),
        .lo_o          (lo),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (dbz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [N-1:0] av, input logic [N-1:0] bv);
        req_valid = 1'b1;
        op        = o;
        a         = av;
        b         = bv;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_ready", req_ready, 1);
        check("rst_dbz", dbz, 0);
        rst_n = 1'b1;

        // MTHI then MFLO, MFHI on consecutive cycles
        send(MTHI, 4'h5, 4'h0);
        check("mthi_hi", hi, 4'h5);
        check("mthi_no_resp", resp_valid, 0);
        send(MFLO, 4'h0, 4'h0);
        check("mflo_valid", resp_valid, 1);
        check("mflo_data", resp_data, 4'h0);
        send(MFHI, 4'h0, 4'h0);
        check("mfhi_valid", resp_valid, 1);
        check("mfhi_data", resp_data, 4'h5);
        tick();
        check("resp_drop", resp_valid, 0);
        check("resp_hold", resp_data, 4'h5);

        // MULTU 13*11 = 0x8F, hi/lo frozen while running
        send(MULTU, 4'd13, 4'd11);
        check("mul_busy0", busy, 1);
        check("mul_ready0", req_ready, 0);
        for (int i = 1; i < N; i++) begin
            tick();
            check("mul_busy", busy, 1);
            check("mul_ready", req_ready, 0);
            check("mul_no_done", done, 0);
            check("mul_hi_hold", hi, 4'h5);
            check("mul_lo_hold", lo, 4'h0);
        end
        tick();
        check("mul_done", done, 1);
        check("mul_idle", busy, 0);
        check("mul_ready_done", req_ready, 1);
        check("mul_hi", hi, 4'h8);
        check("mul_lo", lo, 4'hF);
        tick();
        check("mul_done_pulse", done, 0);

        // DIVU 13/4, then divide by zero, then MULTU clears the flag
        send(DIVU, 4'd13, 4'd4);
        repeat (N) tick();
        check("div_done", done, 1);
        check("div_lo", lo, 4'h3);
        check("div_hi", hi, 4'h1);
        check("div_dbz", dbz, 0);
        send(DIVU, 4'd9, 4'd0);
        repeat (N) tick();
        check("dz_done", done, 1);
        check("dz_hi", hi, 4'h9);
        check("dz_lo", lo, 4'hF);
        check("dz_flag", dbz, 1);
        tick();
        check("dz_flag_hold", dbz, 1);
        send(MULTU, 4'd2, 4'd3);
        check("dz_clear", dbz, 0);
        repeat (N) tick();
        check("mul23_hi", hi, 4'h0);
        check("mul23_lo", lo, 4'h6);

        // MULTU 15*15 with an MFLO held behind it
        req_valid = 1'b1;
        op = MULTU; a = 4'hF; b = 4'hF;
        tick();
        op = MFLO;
        for (int i = 1; i < N; i++) begin
            tick();
            check("queue_ready", req_ready, 0);
            check("queue_no_resp", resp_valid, 0);
        end
        tick();
        check("queue_done", done, 1);
        check("queue_hi", hi, 4'hE);
        check("queue_lo", lo, 4'h1);
        check("queue_no_resp_yet", resp_valid, 0);
        tick();
        req_valid = 1'b0;
        check("queue_resp_valid", resp_valid, 1);
        check("queue_resp_data", resp_data, 4'h1);

`ifdef HILO_SIGNED_EN
        send(3'b110, 4'hD, 4'h5);
        repeat (N) tick();
        check("mult_s_hi", hi, 4'hF);
        check("mult_s_lo", lo, 4'h1);
        send(3'b111, 4'h9, 4'h2);
        repeat (N) tick();
        check("div_s_lo", lo, 4'hD);
        check("div_s_hi", hi, 4'hF);
`else
        send(3'b110, 4'h5, 4'h5);
        check("op110_busy", busy, 0);
        check("op110_ready", req_ready, 1);
        seen_done = 0;
        repeat (N + 1) begin
            tick();
            if (done) seen_done++;
        end
        check("op110_no_done", seen_done, 0);
        check("op110_hi", hi, 4'hE);
        check("op110_lo", lo, 4'h1);
`endif

        // async reset in the middle of DIVU 14/3
        send(DIVU, 4'd14, 4'd3);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 1);
        #3;
        rst_n = 1'b1;
        seen_done = 0;
        repeat (N + 2) begin
            tick();
            if (done) seen_done++;
        end
        check("midrst_no_done", seen_done, 0);
        check("midrst_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
